// File: rtl/avalon_input_pio_capture_pkg.sv
// Shared register map and edge-type encodings for the input capture PIO.
package pio_pkg;

    localparam int BUS_W  = 32;
    localparam int ADDR_W = 2;

    typedef enum logic [ADDR_W-1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_IRQMASK = 2'd1,
        ADDR_EDGECAP = 2'd2,
        ADDR_STATUS  = 2'd3
    } reg_addr_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/avalon_input_pio_capture_if.sv
// Avalon-MM slave bus bundle (host side drives, PIO answers with readdata/irq).
interface avalon_input_pio_capture_if;
    import pio_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              read_n;
    logic              write_n;
    logic [BUS_W-1:0]  writedata;
    logic [BUS_W-1:0]  readdata;
    logic              irq;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/avalon_input_pio_capture_bus_synchronizer.sv
// Multi-flop synchronizer for a bus of independent asynchronous bits.
module bus_synchronizer #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            // Keep stages adjacent and untouched by retiming.
            (* ASYNC_REG = "TRUE" *) logic [DATA_WIDTH-1:0] q_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) q_reg <= '0;
                    else       q_reg <= d;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (reset) q_reg <= '0;
                    else       q_reg <= g_stage[gi-1].q_reg;
                end
            end
        end
    endgenerate

    assign q = g_stage[SYNC_STAGES-1].q_reg;

endmodule

// File: rtl/avalon_input_pio_capture.sv
// Avalon-MM input PIO: synchronized data, sticky W1C edge capture, masked level irq.
module avalon_input_pio_capture
    import pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         in_port,
    avalon_input_pio_capture_if.slave     bus
);

    logic [DATA_WIDTH-1:0] sync_q;
    logic [DATA_WIDTH-1:0] prev_reg;
    logic [DATA_WIDTH-1:0] irqmask_reg, irqmask_next;
    logic [DATA_WIDTH-1:0] edgecap_reg, edgecap_next;
    logic [DATA_WIDTH-1:0] rise, fall, edge_det, clr;
    logic                  irq_reg, irq_next;
    logic [BUS_W-1:0]      readdata_reg, rd_mux;
    logic                  wr_en, rd_en;

    bus_synchronizer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port),
        .q     (sync_q)
    );

    assign rise = sync_q & ~prev_reg;
    assign fall = ~sync_q & prev_reg;

    generate
        if (EDGE_TYPE == EDGE_RISE) begin : g_rise
            assign edge_det = rise;
        end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign edge_det = fall;
        end else begin : g_any
            assign edge_det = rise | fall;
        end
    endgenerate

    assign wr_en = bus.chipselect & ~bus.write_n;
    assign rd_en = bus.chipselect & ~bus.read_n;

    // Clear is applied before the new edge is OR-ed in, so a same-cycle set wins.
    always_comb begin
        clr          = '0;
        irqmask_next = irqmask_reg;
        if (wr_en && bus.address == ADDR_EDGECAP)
            clr = bus.writedata[DATA_WIDTH-1:0];
        if (wr_en && bus.address == ADDR_IRQMASK)
            irqmask_next = bus.writedata[DATA_WIDTH-1:0];
        edgecap_next = (edgecap_reg & ~clr) | edge_det;
        irq_next     = |(edgecap_next & irqmask_next);
    end

    // Read mux sees pre-write register values, so read-during-write returns old data.
    always_comb begin
        rd_mux = '0;
        case (reg_addr_e'(bus.address))
            ADDR_DATA:    rd_mux[DATA_WIDTH-1:0] = sync_q;
            ADDR_IRQMASK: rd_mux[DATA_WIDTH-1:0] = irqmask_reg;
            ADDR_EDGECAP: rd_mux[DATA_WIDTH-1:0] = edgecap_reg;
            ADDR_STATUS:  rd_mux[1:0]            = {|edgecap_reg, irq_reg};
            default:      rd_mux                 = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg     <= '0;
            irqmask_reg  <= '0;
            edgecap_reg  <= '0;
            irq_reg      <= 1'b0;
            readdata_reg <= '0;
        end else begin
            prev_reg    <= sync_q;
            irqmask_reg <= irqmask_next;
            edgecap_reg <= edgecap_next;
            irq_reg     <= irq_next;
            if (rd_en)
                readdata_reg <= rd_mux;
        end
    end

    assign bus.readdata = readdata_reg;
    assign bus.irq      = irq_reg;

endmodule

// File: tb/tb_avalon_input_pio_capture.sv
// Directed bench: three PIO instances (rise/fall/any) sharing one host bus and input.
module tb_avalon_input_pio_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_port = 32'h0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;

    logic [31:0] rdata [3];
    logic [2:0]  irq_w;

    int check_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    avalon_input_pio_capture_if bus [3] ();

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            assign bus[gi].address    = address;
            assign bus[gi].chipselect = chipselect;
            assign bus[gi].read_n     = read_n;
            assign bus[gi].write_n    = write_n;
            assign bus[gi].writedata  = writedata;
            assign rdata[gi]          = bus[gi].readdata;
            assign irq_w[gi]          = bus[gi].irq;

            avalon_input_pio_capture #(
                .DATA_WIDTH  (32),
                .SYNC_STAGES (2),
                .EDGE_TYPE   (gi)
            ) u_dut (
                .clk     (clk),
                .reset   (reset),
                .in_port (in_port),
                .bus     (bus[gi])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        $display("check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic bus_read_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    endtask

    initial begin
        // Reset with all inputs high
        in_port = 32'hFFFF_FFFF;
        reset = 1'b1;
        idle(2);
        check("reset_readdata", rdata[0], 32'h0);
        check("reset_irq", {31'b0, irq_w[0]}, 32'h0);
        reset = 1'b0;
        bus_read(2'd0);
        check("data_lat_cycle1", rdata[0], 32'h0);
        bus_read(2'd0);
        check("data_lat_cycle2", rdata[0], 32'h0);
        bus_read(2'd0);
        check("data_lat_cycle3", rdata[0], 32'hFFFF_FFFF);
        idle(2);
        bus_read(2'd2);
        check("post_reset_rise_cap", rdata[0], 32'hFFFF_FFFF);
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd2);
        check("cap_cleared_all", rdata[0], 32'h0);

        // Rising capture on bit0 with mask enabled
        in_port = 32'h0;
        idle(4);
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_write(2'd1, 32'h1);
        in_port = 32'h1;
        idle(4);
        check("rise_irq_set", {31'b0, irq_w[0]}, 32'h1);
        bus_read(2'd2);
        check("rise_edgecap", rdata[0], 32'h1);
        bus_write(2'd2, 32'h1);
        check("w1c_irq_clear", {31'b0, irq_w[0]}, 32'h0);
        bus_read(2'd2);
        check("w1c_edgecap", rdata[0], 32'h0);

        // Masked edges on bits 3 and 7
        bus_write(2'd1, 32'h0);
        in_port = 32'h89;
        idle(4);
        check("masked_irq_low", {31'b0, irq_w[0]}, 32'h0);
        bus_read(2'd2);
        check("masked_edgecap", rdata[0], 32'h88);
        bus_write(2'd1, 32'h80);
        check("unmask_irq_high", {31'b0, irq_w[0]}, 32'h1);
        bus_read(2'd3);
        check("status_both", rdata[0], 32'h3);

        // Clear of bit5 lands in the same cycle as a new bit5 edge
        in_port = 32'hA9;
        @(posedge clk); @(posedge clk); #1;
        bus_write(2'd2, 32'hA0);
        check("collision_irq", {31'b0, irq_w[0]}, 32'h0);
        bus_read(2'd2);
        check("collision_edgecap", rdata[0], 32'h28);

        // Falling / any-edge instances, bit2 toggled 1->0->1
        bus_write(2'd2, 32'hFFFF_FFFF);
        in_port = 32'hAD;
        idle(4);
        bus_write(2'd2, 32'hFFFF_FFFF);
        in_port = 32'hA9;
        idle(4);
        bus_read(2'd2);
        check("fall_toggle1_rise", rdata[0], 32'h0);
        check("fall_toggle1_fall", rdata[1], 32'h4);
        check("fall_toggle1_any", rdata[2], 32'h4);
        bus_write(2'd2, 32'h4);
        in_port = 32'hAD;
        idle(4);
        bus_read(2'd2);
        check("rise_toggle2_rise", rdata[0], 32'h4);
        check("rise_toggle2_fall", rdata[1], 32'h0);
        check("rise_toggle2_any", rdata[2], 32'h4);

        // Back-to-back reads of every register
        bus_read(2'd0);
        check("b2b_data", rdata[0], 32'hAD);
        bus_read(2'd1);
        check("b2b_irqmask", rdata[0], 32'h80);
        bus_read(2'd2);
        check("b2b_edgecap", rdata[0], 32'h4);
        bus_read(2'd3);
        check("b2b_status", rdata[0], 32'h2);
        idle(2);
        check("readdata_hold", rdata[0], 32'h2);

        // Read and write of IRQMASK in the same cycle
        bus_read_write(2'd1, 32'h0F);
        check("rw_old_value", rdata[0], 32'h80);
        check("rw_irq", {31'b0, irq_w[0]}, 32'h1);
        bus_read(2'd1);
        check("rw_new_value", rdata[0], 32'h0F);

        // Strobes without chipselect are ignored
        address = 2'd1; writedata = 32'h0; write_n = 1'b0; read_n = 1'b0;
        idle(1);
        write_n = 1'b1; read_n = 1'b1;
        check("nocs_read_ignored", rdata[0], 32'h0F);
        bus_read(2'd1);
        check("nocs_write_ignored", rdata[0], 32'h0F);

        // Reset in the middle of operation
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("midreset_irq", {31'b0, irq_w[0]}, 32'h0);
        check("midreset_readdata", rdata[0], 32'h0);
        bus_read(2'd1);
        check("midreset_irqmask", rdata[0], 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
